// File: rtl/omem_pkg.sv
// rtl/omem_pkg.sv - shared register map, CTRL bit positions and STATUS layout for omem_banked
// Purpose: constants and types shared by omem_banked and omem_bank.
// Contents: STATUS_OFS / CTRL_OFS byte offsets inside a core window,
//           CTRL bit positions, status_t packed STATUS register layout.
package omem_pkg;

    localparam logic [31:0] STATUS_OFS = 32'h0000_0100;
    localparam logic [31:0] CTRL_OFS   = 32'h0000_0104;

    localparam int CTRL_MODE_BIT  = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    typedef struct packed {
        logic [15:0] frame_count;
        logic [14:0] popcount;
        logic        busy;
    } status_t;

endpackage

// File: rtl/omem_bank.sv
// rtl/omem_bank.sv - per-core spike frame storage with CTRL, frame counter and popcount sequencer
// Purpose: holds one core's spike words, CTRL.mode, frame_count, frame_valid and
//          (with OMEM_POPCOUNT_EN defined) the word-serial popcount sequencer.
// Ports:   clk, rst (async, active-high)
//          capture, spike           - one-cycle frame capture strobe and frame bits
//          word_wr, word_idx, wdata, wsel - byte-lane write into a spike word
//          ctrl_wr                  - byte-lane write of CTRL (lane 0 used)
//          status_rd                - STATUS read strobe, clears frame_valid
//          word_rdata, status, ctrl - read values for the top-level read mux
//          frame_valid              - new frame captured and not yet read
// Macro:   OMEM_POPCOUNT_EN enables the popcount sequencer.
module omem_bank
    import omem_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int WORDS       = NUM_NEURONS / 32,
    parameter int IW          = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic [NUM_NEURONS-1:0] spike,
    input  logic                   word_wr,
    input  logic [IW-1:0]          word_idx,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wsel,
    input  logic                   ctrl_wr,
    input  logic                   status_rd,
    output logic [31:0]            word_rdata,
    output logic [31:0]            status,
    output logic [31:0]            ctrl,
    output logic                   frame_valid
);

    logic [31:0] words [WORDS];
    logic        mode;
    logic [15:0] frame_count;
    logic        clear_now;
    logic        busy;
    logic [14:0] popcount;
    status_t     st;

    assign clear_now = ctrl_wr & wsel[0] & wdata[CTRL_CLEAR_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WORDS; w++) words[w] <= '0;
            mode        <= 1'b0;
            frame_count <= '0;
            frame_valid <= 1'b0;
        end else begin
            if (ctrl_wr && wsel[0]) mode <= wdata[CTRL_MODE_BIT];
            for (int w = 0; w < WORDS; w++) begin
                // Capture beats a same-cycle bus write; a same-cycle clear
                // empties the accumulator before the new frame is ORed in.
                if (capture) begin
                    words[w] <= ((mode && !clear_now) ? words[w] : 32'h0)
                                | spike[NUM_NEURONS-1-32*w -: 32];
                end else if (clear_now) begin
                    words[w] <= '0;
                end else if (word_wr && word_idx == IW'(w)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wsel[b]) words[w][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (capture) frame_count <= frame_count + 16'd1;
            if (capture)        frame_valid <= 1'b1;
            else if (status_rd) frame_valid <= 1'b0;
        end
    end

`ifdef OMEM_POPCOUNT_EN
    logic [IW-1:0] pc_idx;
    logic [15:0]   pc_sum;

    assign pc_sum = {1'b0, popcount} + 16'($countones(words[pc_idx]));

    // One word per cycle after each capture; a new capture restarts the walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            popcount <= '0;
            pc_idx   <= '0;
        end else if (capture) begin
            busy     <= 1'b1;
            popcount <= '0;
            pc_idx   <= '0;
        end else if (busy) begin
            popcount <= pc_sum[15] ? 15'h7FFF : pc_sum[14:0];
            pc_idx   <= pc_idx + 1'b1;
            if (pc_idx == IW'(WORDS-1)) busy <= 1'b0;
        end
    end
`else
    assign busy     = 1'b0;
    assign popcount = '0;
`endif

    assign word_rdata = words[word_idx];

    always_comb begin
        st.frame_count = frame_count;
        st.popcount    = popcount;
        st.busy        = busy;
    end
    assign status = st;

    always_comb begin
        ctrl                = '0;
        ctrl[CTRL_MODE_BIT] = mode;
    end

endmodule

// File: rtl/omem_banked.sv
// rtl/omem_banked.sv - banked Wishbone-readable spike output memory for NUM_CORES SNN cores
// Purpose: decodes one CORE_STRIDE window per core, issues single-cycle Wishbone
//          acks with registered read data, and routes writes/captures to omem_bank.
// Ports:   wb_clk_i, wb_rst_i (async, active-high)
//          wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i, wbs_ack_o/dat_o - Wishbone classic slave
//          capture_i[NUM_CORES], spike_i[NUM_CORES*NUM_NEURONS]     - frame capture inputs
//          frame_valid_o[NUM_CORES]                                 - unread-frame flags
// Macro:   OMEM_POPCOUNT_EN (passed through to omem_bank).
module omem_banked
    import omem_pkg::*;
#(
    parameter int          NUM_CORES   = 2,
    parameter int          NUM_NEURONS = 256,
    parameter logic [31:0] OMEM_BASE   = 32'h8004_0000,
    parameter logic [31:0] CORE_STRIDE = 32'h0001_0000
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_we_i,
    input  logic [3:0]                       wbs_sel_i,
    input  logic [31:0]                      wbs_adr_i,
    input  logic [31:0]                      wbs_dat_i,
    output logic                             wbs_ack_o,
    output logic [31:0]                      wbs_dat_o,
    input  logic [NUM_CORES-1:0]             capture_i,
    input  logic [NUM_CORES*NUM_NEURONS-1:0] spike_i,
    output logic [NUM_CORES-1:0]             frame_valid_o
);

    localparam int WORDS = NUM_NEURONS / 32;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [31:0]          core_ofs [NUM_CORES];
    logic [NUM_CORES-1:0] core_hit;
    logic                 hit;
    logic [CW-1:0]        hit_core;
    logic [31:0]          offset;
    logic                 is_word, is_status, is_ctrl;
    logic                 req;
    logic [31:0]          rdata;
    logic [31:0]          bank_word   [NUM_CORES];
    logic [31:0]          bank_status [NUM_CORES];
    logic [31:0]          bank_ctrl   [NUM_CORES];

    // Unsigned subtraction wraps addresses below a window to large values,
    // so a single compare bounds the window on both sides.
    for (genvar c = 0; c < NUM_CORES; c++) begin : g_dec
        assign core_ofs[c] = wbs_adr_i - (OMEM_BASE + 32'(c) * CORE_STRIDE);
        assign core_hit[c] = core_ofs[c] < CORE_STRIDE;
    end

    always_comb begin
        hit      = 1'b0;
        hit_core = '0;
        offset   = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (core_hit[c]) begin
                hit      = 1'b1;
                hit_core = CW'(c);
                offset   = core_ofs[c];
            end
        end
    end

    assign is_word   = offset < 32'(4 * WORDS);
    assign is_status = {offset[31:2], 2'b00} == STATUS_OFS;
    assign is_ctrl   = {offset[31:2], 2'b00} == CTRL_OFS;
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_bank
        logic en;
        assign en = req & hit & (hit_core == CW'(c));

        omem_bank #(
            .NUM_NEURONS (NUM_NEURONS),
            .WORDS       (WORDS),
            .IW          (IW)
        ) u_bank (
            .clk         (wb_clk_i),
            .rst         (wb_rst_i),
            .capture     (capture_i[c]),
            .spike       (spike_i[c*NUM_NEURONS +: NUM_NEURONS]),
            .word_wr     (en & wbs_we_i & is_word),
            .word_idx    (offset[IW+1:2]),
            .wdata       (wbs_dat_i),
            .wsel        (wbs_sel_i),
            .ctrl_wr     (en & wbs_we_i & is_ctrl),
            .status_rd   (en & ~wbs_we_i & is_status),
            .word_rdata  (bank_word[c]),
            .status      (bank_status[c]),
            .ctrl        (bank_ctrl[c]),
            .frame_valid (frame_valid_o[c])
        );
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (hit && hit_core == CW'(c)) begin
                if (is_word)        rdata = bank_word[c];
                else if (is_status) rdata = bank_status[c];
                else if (is_ctrl)   rdata = bank_ctrl[c];
            end
        end
    end

    // ack <= req alternates with ack, so a held stb yields ack every other cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_omem_banked.sv
// tb/tb_omem_banked.sv - directed scoreboard bench for omem_banked
module tb_omem_banked;

    localparam int NC = 2;
    localparam int NN = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             cyc, stb, we;
    logic [3:0]       sel;
    logic [31:0]      adr, wdat;
    logic             ack;
    logic [31:0]      rdat;
    logic [NC-1:0]    capture;
    logic [NC*NN-1:0] spike;
    logic [NC-1:0]    fv;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          fc0 = 0;
    int          fc1 = 0;

    omem_banked #(
        .NUM_CORES   (NC),
        .NUM_NEURONS (NN),
        .OMEM_BASE   (32'h8004_0000),
        .CORE_STRIDE (32'h0001_0000)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .capture_i     (capture),
        .spike_i       (spike),
        .frame_valid_o (fv)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int fc, input int pc);
`ifdef OMEM_POPCOUNT_EN
        logic [31:0] p;
        p = 32'(pc);
        return {fc[15:0], p[14:0], 1'b0};
`else
        return {fc[15:0], 16'h0000} | (32'(pc) & 32'h0);
`endif
    endfunction

    task automatic set_word(input int core, input int w, input logic [31:0] v);
        spike[core*NN + NN-1-32*w -: 32] = v;
    endtask

    task automatic do_capture(input logic [NC-1:0] cap);
        @(negedge clk);
        capture = cap;
        @(negedge clk);
        capture = '0;
    endtask

    // One Wishbone cycle; cap is asserted in the same cycle the request is sampled.
    task automatic wb_cycle(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input logic [NC-1:0] cap, input logic [31:0] exp);
        int          n;
        logic [31:0] e;
        if (!w) exp_q.push_back(exp);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; capture = cap;
        @(negedge clk);
        capture = '0;
        n = 1;
        while (ack !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_latency"}, 32'(n), 32'd1);
        if (!w) begin
            e = exp_q.pop_front();
            check(tag, rdat, e);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; wdat = '0; capture = '0; spike = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_fv", {30'b0, fv}, 32'd0);
        rst = 1'b0;

        wb_cycle("rst_c0_word0", 1'b0, 32'h8004_0000, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("rst_c1_status", 1'b0, 32'h8005_0100, 0, 4'hF, 2'b00, 32'h0);

        // Overwrite capture, MSB-first word 0
        set_word(0, 0, 32'hDEAD_BEEF);
        do_capture(2'b01); fc0++;
        check("fv0_set", {31'b0, fv[0]}, 32'd1);
        wb_cycle("c0_word0", 1'b0, 32'h8004_0000, 0, 4'hF, 2'b00, 32'hDEAD_BEEF);
        repeat (10) @(negedge clk);
        wb_cycle("c0_status", 1'b0, 32'h8004_0100, 0, 4'hF, 2'b00, exp_status(fc0, 24));
        check("fv0_clr", {31'b0, fv[0]}, 32'd0);

        // Sticky OR accumulate on core 1 word 7
        wb_cycle("c1_ctrl_wr", 1'b1, 32'h8005_0104, 32'h1, 4'hF, 2'b00, 32'h0);
        wb_cycle("c1_ctrl_rd", 1'b0, 32'h8005_0104, 0, 4'hF, 2'b00, 32'h1);
        spike = '0;
        set_word(1, 7, 32'h0000_000F);
        do_capture(2'b10); fc1++;
        set_word(1, 7, 32'h0000_00F0);
        do_capture(2'b10); fc1++;
        wb_cycle("c1_word7_or", 1'b0, 32'h8005_001C, 0, 4'hF, 2'b00, 32'h0000_00FF);
        check("fv1_set", {31'b0, fv[1]}, 32'd1);
        repeat (10) @(negedge clk);

        // STATUS read clears frame_valid; same-cycle capture keeps it set
        wb_cycle("c1_status", 1'b0, 32'h8005_0100, 0, 4'hF, 2'b00, exp_status(fc1, 8));
        check("fv1_clr", {31'b0, fv[1]}, 32'd0);
        spike = '0;
        wb_cycle("c1_status_cap", 1'b0, 32'h8005_0100, 0, 4'hF, 2'b10, exp_status(fc1, 8));
        fc1++;
        check("fv1_set_wins", {31'b0, fv[1]}, 32'd1);

        // Capture beats a same-cycle write to the same word
        spike = '0;
        set_word(0, 0, 32'hCAFE_F00D);
        wb_cycle("wr_vs_cap", 1'b1, 32'h8004_0000, 32'h1234_5678, 4'hF, 2'b01, 32'h0);
        fc0++;
        wb_cycle("wr_vs_cap_rd", 1'b0, 32'h8004_0000, 0, 4'hF, 2'b00, 32'hCAFE_F00D);

        // Byte-lane write
        wb_cycle("lane_wr", 1'b1, 32'h8004_0004, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0);
        wb_cycle("lane_rd", 1'b0, 32'h8004_0004, 0, 4'hF, 2'b00, 32'h00BB_00DD);

        // CTRL.clear zeroes the words and self-clears
        wb_cycle("c0_clear", 1'b1, 32'h8004_0104, 32'h2, 4'hF, 2'b00, 32'h0);
        wb_cycle("c0_clr_w0", 1'b0, 32'h8004_0000, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("c0_clr_w1", 1'b0, 32'h8004_0004, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("c0_ctrl_rd", 1'b0, 32'h8004_0104, 0, 4'hF, 2'b00, 32'h0);

        // Clear together with capture: clear first, then OR the new frame
        spike = '0;
        set_word(1, 7, 32'h0000_0100);
        wb_cycle("c1_clr_cap", 1'b1, 32'h8005_0104, 32'h3, 4'hF, 2'b10, 32'h0);
        fc1++;
        wb_cycle("c1_clr_cap_rd", 1'b0, 32'h8005_001C, 0, 4'hF, 2'b00, 32'h0000_0100);
        wb_cycle("c1_ctrl_rd2", 1'b0, 32'h8005_0104, 0, 4'hF, 2'b00, 32'h1);

        // Unmapped and out-of-window accesses
        wb_cycle("unmapped_108", 1'b0, 32'h8004_0108, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("beyond_cores", 1'b0, 32'h8006_0000, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("below_base", 1'b0, 32'h8003_FFFC, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("unmapped_wr", 1'b1, 32'h8004_0200, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0);
        wb_cycle("unmapped_rd", 1'b0, 32'h8004_0200, 0, 4'hF, 2'b00, 32'h0);

        // Both cores capture in the same cycle
        spike = '0;
        set_word(0, 0, 32'h1111_1111);
        set_word(1, 0, 32'h2222_2222);
        do_capture(2'b11); fc0++; fc1++;
        wb_cycle("dual_c0", 1'b0, 32'h8004_0000, 0, 4'hF, 2'b00, 32'h1111_1111);
        wb_cycle("dual_c1", 1'b0, 32'h8005_0000, 0, 4'hF, 2'b00, 32'h2222_2222);
        wb_cycle("dual_c1_w7", 1'b0, 32'h8005_001C, 0, 4'hF, 2'b00, 32'h0000_0100);
        repeat (10) @(negedge clk);
        wb_cycle("dual_c1_status", 1'b0, 32'h8005_0100, 0, 4'hF, 2'b00, exp_status(fc1, 9));

`ifdef OMEM_POPCOUNT_EN
        spike = '0;
        spike[NN-1:0] = '1;
        do_capture(2'b01); fc0++;
        wb_cycle("pc_busy", 1'b0, 32'h8004_0100, 0, 4'hF, 2'b00,
                 {fc0[15:0], 15'd32, 1'b1});
        repeat (10) @(negedge clk);
        wb_cycle("pc_done", 1'b0, 32'h8004_0100, 0, 4'hF, 2'b00, exp_status(fc0, 256));
`endif

        // Reset in the middle of a cycle: no ack, state cleared
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8004_0000; sel = 4'hF;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'b0, ack}, 32'd0);
        check("rst_mid_fv", {30'b0, fv}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("rst_mid_ack2", {31'b0, ack}, 32'd0);
        check("rst_mid_dat", rdat, 32'd0);
        rst = 1'b0;
        wb_cycle("post_rst_c0_w0", 1'b0, 32'h8004_0000, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("post_rst_c1_w7", 1'b0, 32'h8005_001C, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("post_rst_c1_status", 1'b0, 32'h8005_0100, 0, 4'hF, 2'b00, 32'h0);
        wb_cycle("post_rst_c1_ctrl", 1'b0, 32'h8005_0104, 0, 4'hF, 2'b00, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/omem_banked.md
OMEM_BANKED -- requirements
Module: omem_banked

Interface
REQ-001 SHALL provide parameter NUM_CORES, default 2, number of SNN cores served.
REQ-002 SHALL provide parameter NUM_NEURONS, default 256, spikes per core, a multiple of 32; WORDS = NUM_NEURONS/32.
REQ-003 SHALL provide parameter OMEM_BASE, default 32'h80040000, base byte address of core 0.
REQ-004 SHALL provide parameter CORE_STRIDE, default 32'h00010000, byte distance between core windows.
REQ-005 SHALL have port wb_clk_i, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i, input, 1 each, Wishbone classic controls.
REQ-008 SHALL have ports wbs_sel_i (input, 4), wbs_adr_i (input, 32), wbs_dat_i (input, 32), Wishbone byte lanes, address and write data.
REQ-009 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32), Wishbone acknowledge and read data.
REQ-010 SHALL have port capture_i, input, NUM_CORES, per-core one-cycle capture strobe.
REQ-011 SHALL have port spike_i, input, NUM_CORES*NUM_NEURONS, core c at slice [c*NUM_NEURONS +: NUM_NEURONS].
REQ-012 SHALL have port frame_valid_o, output, NUM_CORES, per-core "new frame captured, unread".

Function
REQ-013 SHALL decode core window c when adr - (OMEM_BASE + c*CORE_STRIDE) < CORE_STRIDE; the offset is byte-addressed and word index = offset[..:2].
REQ-014 SHALL map offsets 0x000..4*(WORDS-1) to spike words; word 0 = spike bits [NUM_NEURONS-1 -: 32] (MSB-first).
REQ-015 SHALL map offset 0x100 to STATUS (RO): [31:16] frame_count, [15:1] popcount, [0] busy.
REQ-016 SHALL map offset 0x104 to CTRL (RW): bit 0 mode (0 = overwrite, 1 = sticky OR-accumulate); bit 1 clear (self-clearing, zeroes the spike words of that core).
REQ-017 SHALL assert wbs_ack_o exactly one cycle after cyc&stb is sampled with ack low, for one cycle; no back-to-back ack without stb re-sampled.
REQ-018 SHALL return registered read data with ack; unmapped or out-of-window addresses ack with 32'h0 and ignore writes.
REQ-019 SHALL apply writes to spike words and CTRL per wbs_sel_i byte lane in the ack cycle.
REQ-020 On capture_i[c], SHALL load all WORDS of core c in one cycle: overwrite or OR per mode, increment frame_count (wraps 16'hFFFF->0), set frame_valid_o[c].
REQ-021 SHALL give capture precedence over a same-cycle Wishbone write to the same core's spike words; the write is dropped but still acked.
REQ-022 SHALL clear frame_valid_o[c] on a STATUS read of core c; a same-cycle capture sets it (set wins).
REQ-023 SHALL treat CTRL.clear and capture in the same cycle as clear-then-capture.
REQ-024 SHALL process multiple cores capturing in the same cycle independently.

Reset
REQ-025 SHALL, on wb_rst_i, zero all spike words, CTRL, frame_count, popcount, busy, frame_valid_o, wbs_ack_o and wbs_dat_o immediately.
REQ-026 SHALL abort an in-flight Wishbone cycle or popcount on reset; no ack is issued for it.

Configuration
REQ-027 With OMEM_POPCOUNT_EN defined, SHALL compute popcount after each capture one word per cycle (busy=1 for WORDS cycles, popcount saturating at 15 bits); a capture during busy restarts the count.
REQ-028 Without OMEM_POPCOUNT_EN, STATUS[15:0] SHALL read 0 and no counter logic is built.

Structure
REQ-029 SHALL place register offsets (0x100, 0x104), CTRL bit positions and a STATUS struct typedef in package omem_pkg.
REQ-030 SHALL instantiate one sub-module omem_bank per core, holding spike words, CTRL, counters and the popcount sequencer; the top holds decode, ack and read mux.

Verification
REQ-031 Capture core 0 with spike_i[255:224]=32'hDEADBEEF, mode 0; read 0x80040000 -> 32'hDEADBEEF, ack one cycle after stb.
REQ-032 Mode 1, capture 32'h0000000F then 32'h000000F0 on word 7 of core 1; read 0x8005001C -> 32'h000000FF, STATUS[31:16]=2.
REQ-033 Capture and write to word 0 of core 0 in the same cycle -> captured value retained, ack still issued.
REQ-034 OMEM_POPCOUNT_EN: capture all-ones on core 0 -> busy for 8 cycles, then STATUS[15:1]=256 saturated to 15-bit field value 256, busy=0.
REQ-035 Read STATUS of core 1 -> frame_valid_o[1] drops the next cycle; capture in the same cycle keeps it at 1.
REQ-036 Assert wb_rst_i mid-cycle (stb high, ack not yet issued) -> no ack, all reads return 0 after release.
